// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the register file's single 8:1 read port among N_REQ requesters.
// Optional RFARB_LOCK_EN adds lock_i: a locked requester may take up to 4 back-to-back reads.
module rf_read_arbiter #(
  parameter int W_width = 32,
  parameter int N_REQ   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [3*N_REQ-1:0]   addr_i,
  input  logic [W_width-1:0]   rdata_i,
  output logic [2:0]           select_o,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     rvalid_o,
  output logic [W_width-1:0]   rdata_o,
  output logic                 busy_o
`ifdef RFARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]     lock_i
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

  state_t               r_state, w_state_nx;
  logic [IW-1:0]        r_win, r_ptr, w_pick, w_base;
  logic [2:0]           r_addr;
  logic [W_width-1:0]   r_rdata;
  logic [N_REQ-1:0]     w_mask;
  logic                 w_load, w_hit;
  logic [2:0]           w_addr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_addr
    assign w_addr[k] = addr_i[3*k +: 3];
  end

  // First set bit of m strictly after base, wrapping modulo N_REQ.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] m, input logic [IW-1:0] base);
    logic [IW-1:0] p;
    logic [IW:0]   s;
    p = base;
    for (int i = N_REQ; i >= 1; i--) begin
      s = {1'b0, base} + (IW+1)'(i);
      if (s >= (IW+1)'(N_REQ)) s = s - (IW+1)'(N_REQ);
      if (m[s[IW-1:0]]) p = s[IW-1:0];
    end
    return p;
  endfunction

`ifdef RFARB_LOCK_EN
  logic [1:0] r_lock_cnt;
`endif

  always_comb begin
    w_mask     = req_i;
    w_base     = r_ptr;
    w_hit      = 1'b0;
    w_state_nx = r_state;
    w_load     = 1'b0;
    if (r_state == S_RESP) begin
      w_mask[r_win] = 1'b0;
      w_base        = r_win;
`ifdef RFARB_LOCK_EN
      w_hit = lock_i[r_win] && req_i[r_win] && (r_lock_cnt != 2'd3);
`endif
    end
    w_pick = w_hit ? r_win : rr_pick(w_mask, w_base);
    case (r_state)
      S_IDLE: if (|w_mask) begin
        w_state_nx = S_READ;
        w_load     = 1'b1;
      end
      S_READ: w_state_nx = S_RESP;
      S_RESP: begin
        if (w_hit || (|w_mask)) begin
          w_state_nx = S_READ;
          w_load     = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_ptr   <= IW'(N_REQ-1);
      r_addr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_win  <= w_pick;
        r_addr <= w_addr[w_pick];
      end
      // Mux is combinational: data is valid during READ.
      if (r_state == S_READ) r_rdata <= rdata_i;
      if (r_state == S_RESP && !w_hit) r_ptr <= r_win;
    end
  end

`ifdef RFARB_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               r_lock_cnt <= '0;
    else if (r_state == S_RESP) r_lock_cnt <= w_hit ? r_lock_cnt + 2'd1 : 2'd0;
  end
`endif

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (r_state == S_READ) gnt_o[r_win]    = 1'b1;
    if (r_state == S_RESP) rvalid_o[r_win] = 1'b1;
  end

  assign select_o = r_addr;
  assign rdata_o  = r_rdata;
  assign busy_o   = (r_state != S_IDLE);

endmodule
